// File: rtl/eth_pcs_pkg.sv
// Shared 64b/66b PCS definitions: sync header codes, block-lock states and the
// x^58+x^39+1 descramble step used by the RX path and by bench scrambler models.
package eth_pcs_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;
  localparam int         SCR_W   = 58;

  typedef enum logic [2:0] {
    ST_LOCK_INIT = 3'd0,
    ST_RESET_CNT = 3'd1,
    ST_TEST_SH   = 3'd2,
    ST_SLIP      = 3'd3,
    ST_SLIP_WAIT = 3'd4
  } block_lock_state_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [SCR_W-1:0] state;
  } descr_t;

  function automatic logic is_valid_sh(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

  // Bit 0 is the oldest bit on the wire; the state shifts in scrambled bits.
  function automatic descr_t descramble(input logic [31:0] din, input logic [SCR_W-1:0] sin);
    descr_t           res;
    logic [SCR_W-1:0] s;
    s        = sin;
    res.data = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      res.data[i] = din[i] ^ s[38] ^ s[57];
      s           = {s[SCR_W-2:0], din[i]};
    end
    res.state = s;
    return res;
  endfunction

endpackage

// File: rtl/eth_rx_descrambler.sv
// Self-synchronising 32-bit descrambler; state advances only on valid beats so
// gearbox pause beats leave the polynomial state untouched.
module eth_rx_descrambler
  import eth_pcs_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_data,
  input  logic        i_data_valid,
  output logic [31:0] o_data
);

  logic [SCR_W-1:0] state_q;
  logic [SCR_W-1:0] state_d;
  descr_t           step_s;

  always_comb begin
    step_s = descramble(i_data, state_q);
    if (i_data_valid) begin
      state_d = step_s.state;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= {SCR_W{1'b0}};
    end else begin
      state_q <= state_d;
    end
  end

  assign o_data = step_s.data;

endmodule

// File: rtl/eth_rx_block_sync.sv
// 64b/66b RX block lock with bitslip hunting, payload descrambling and a single
// registered output stage that forwards beats only while locked.
module eth_rx_block_sync
  import eth_pcs_pkg::*;
#(
  parameter int DATAPATH_WIDTH = 32,
  parameter int SH_WINDOW      = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DATAPATH_WIDTH-1:0] i_data,
  input  logic                      i_data_valid,
  input  logic [1:0]                i_header,
  input  logic                      i_header_valid,
  output logic                      o_bitslip,
  output logic                      o_block_lock,
  output logic [DATAPATH_WIDTH-1:0] o_data,
  output logic                      o_data_valid,
  output logic [1:0]                o_header,
  output logic                      o_header_valid,
  output logic [15:0]               o_sh_err_cnt
);

  if (DATAPATH_WIDTH != 32) begin : g_bad_width
    $error("eth_rx_block_sync supports DATAPATH_WIDTH=32 only");
  end

  localparam int SH_CNT_W = $clog2(SH_WINDOW + 1);
  localparam int INV_W    = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W   = $clog2(SLIP_WAIT + 1);

  block_lock_state_t   state_q, state_d;
  logic [SH_CNT_W-1:0] sh_cnt_q, sh_cnt_d, sh_cnt_inc_s;
  logic [INV_W-1:0]    invld_q, invld_d, invld_inc_s;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                lock_q, lock_d;
  logic                bitslip_q, bitslip_d;
  logic [15:0]         err_q, err_d;
  logic [31:0]         data_q, data_d, descr_s;
  logic                dv_q, dv_d;
  logic [1:0]          hdr_q, hdr_d;
  logic                hv_q, hv_d;
  logic                eval_s, sh_bad_s, inv_full_s, win_full_s;

  eth_rx_descrambler u_descr (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_data       (descr_s)
  );

  assign eval_s       = i_data_valid && i_header_valid;
  assign sh_bad_s     = !is_valid_sh(i_header);
  assign sh_cnt_inc_s = sh_cnt_q + SH_CNT_W'(1);
  assign invld_inc_s  = invld_q + {{(INV_W-1){1'b0}}, sh_bad_s};
  assign inv_full_s   = (invld_inc_s == INV_W'(SH_INVALID_MAX));
  assign win_full_s   = (sh_cnt_inc_s == SH_CNT_W'(SH_WINDOW));

  // Lock FSM next state; a lost lock takes priority over a completed window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOCK_INIT: state_d = ST_RESET_CNT;
      ST_RESET_CNT: state_d = ST_TEST_SH;
      ST_TEST_SH: begin
        if (!eval_s) begin
          state_d = ST_TEST_SH;
        end else if (!lock_q && sh_bad_s) begin
          state_d = ST_SLIP;
        end else if (lock_q && inv_full_s) begin
          state_d = ST_SLIP;
        end else if (win_full_s) begin
          state_d = ST_RESET_CNT;
        end else begin
          state_d = ST_TEST_SH;
        end
      end
      ST_SLIP: state_d = ST_SLIP_WAIT;
      ST_SLIP_WAIT: begin
        if (wait_q == WAIT_W'(0)) begin
          state_d = ST_RESET_CNT;
        end else begin
          state_d = ST_SLIP_WAIT;
        end
      end
      default: state_d = ST_LOCK_INIT;
    endcase
  end

  always_comb begin
    sh_cnt_d  = sh_cnt_q;
    invld_d   = invld_q;
    wait_d    = wait_q;
    lock_d    = lock_q;
    bitslip_d = 1'b0;
    err_d     = err_q;
    case (state_q)
      ST_LOCK_INIT: begin
        lock_d   = 1'b0;
        sh_cnt_d = SH_CNT_W'(0);
        invld_d  = INV_W'(0);
      end
      ST_RESET_CNT: begin
        sh_cnt_d = SH_CNT_W'(0);
        invld_d  = INV_W'(0);
      end
      ST_TEST_SH: begin
        if (eval_s) begin
          sh_cnt_d = sh_cnt_inc_s;
          invld_d  = invld_inc_s;
          if (lock_q && sh_bad_s && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
          end else begin
            err_d = err_q;
          end
          if (lock_q && inv_full_s) begin
            lock_d = 1'b0;
          end else if (win_full_s && (invld_inc_s == INV_W'(0))) begin
            lock_d = 1'b1;
          end else begin
            lock_d = lock_q;
          end
        end else begin
          sh_cnt_d = sh_cnt_q;
        end
      end
      ST_SLIP: begin
        bitslip_d = 1'b1;
        wait_d    = WAIT_W'(SLIP_WAIT);
      end
      ST_SLIP_WAIT: begin
        if (wait_q != WAIT_W'(0)) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          wait_d = wait_q;
        end
      end
      default: begin
        lock_d = 1'b0;
      end
    endcase
  end

  // Output stage qualifies on the lock value held before this cycle's update.
  always_comb begin
    dv_d = i_data_valid && lock_q;
    hv_d = i_data_valid && i_header_valid && lock_q;
    if (dv_d) begin
      data_d = descr_s;
    end else begin
      data_d = data_q;
    end
    if (hv_d) begin
      hdr_d = i_header;
    end else begin
      hdr_d = hdr_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_LOCK_INIT;
      sh_cnt_q  <= SH_CNT_W'(0);
      invld_q   <= INV_W'(0);
      wait_q    <= WAIT_W'(0);
      lock_q    <= 1'b0;
      bitslip_q <= 1'b0;
      err_q     <= 16'h0000;
      data_q    <= 32'h0000_0000;
      dv_q      <= 1'b0;
      hdr_q     <= 2'b00;
      hv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_cnt_q  <= sh_cnt_d;
      invld_q   <= invld_d;
      wait_q    <= wait_d;
      lock_q    <= lock_d;
      bitslip_q <= bitslip_d;
      err_q     <= err_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      hdr_q     <= hdr_d;
      hv_q      <= hv_d;
    end
  end

  assign o_bitslip      = bitslip_q;
  assign o_block_lock   = lock_q;
  assign o_data         = data_q;
  assign o_data_valid   = dv_q;
  assign o_header       = hdr_q;
  assign o_header_valid = hv_q;
  assign o_sh_err_cnt   = err_q;

endmodule

// File: tb/tb_eth_rx_block_sync.sv
// Bench for eth_rx_block_sync: reference scrambler + gearbox/slip model feeding a
// latency-1 scoreboard, a header-validity vector table and lock/slip/reset sequences.
module tb_eth_rx_block_sync;
  import eth_pcs_pkg::*;

  localparam int SLIP_WAIT_C = 32;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic [1:0]  i_header;
  logic        i_header_valid;
  logic        o_bitslip;
  logic        o_block_lock;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic [1:0]  o_header;
  logic        o_header_valid;
  logic [15:0] o_sh_err_cnt;

  eth_rx_block_sync #(
    .DATAPATH_WIDTH (32),
    .SH_WINDOW      (64),
    .SH_INVALID_MAX (16),
    .SLIP_WAIT      (SLIP_WAIT_C)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_data         (i_data),
    .i_data_valid   (i_data_valid),
    .i_header       (i_header),
    .i_header_valid (i_header_valid),
    .o_bitslip      (o_bitslip),
    .o_block_lock   (o_block_lock),
    .o_data         (o_data),
    .o_data_valid   (o_data_valid),
    .o_header       (o_header),
    .o_header_valid (o_header_valid),
    .o_sh_err_cnt   (o_sh_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] data;
    logic        dv;
    logic [1:0]  hdr;
    logic        hv;
  } sb_t;

  typedef struct {
    logic [1:0]  hdr;
    logic        dv;
    logic        hv;
    logic [15:0] exp_err;
    logic        exp_lock;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        tbl[7];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [57:0] scr_s = 58'h0;
  logic [31:0] last_data = 32'h0;
  int          cyc = 0;
  int          slip_cnt = 0;
  int          last_slip_cyc = 0;
  int          min_gap = 100000;
  int          slip_off = 0;
  bit          slip_track = 1'b1;
  bit          mode_ctrl = 1'b0;
  bit          pause_en = 1'b0;
  int          beat_no = 0;
  int          inj_bad = 0;
  int          hdr_since_slip = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: scramble plaintext, drive, push expectation, pop and compare after the edge.
  task automatic beat(input logic [31:0] plain, input logic dv, input logic [1:0] hdr, input logic hv);
    logic [31:0] sc;
    sb_t         e;
    sb_t         g;
    sc = plain;
    if (dv) begin
      for (int i = 0; i < 32; i++) begin
        sc[i] = plain[i] ^ scr_s[38] ^ scr_s[57];
        scr_s = {scr_s[56:0], sc[i]};
      end
    end else begin
      sc = $urandom;
    end
    i_data = sc; i_data_valid = dv; i_header = hdr; i_header_valid = hv;
    e.data = plain; e.dv = dv; e.hdr = hdr; e.hv = hv && dv;
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    cyc++;
    g = sb_q.pop_front();
    if (!g.dv) chk("dv_on_pause", 32'(o_data_valid), 32'd0);
    if (o_data_valid) begin
      chk("data", o_data, g.data);
      chk("hv", 32'(o_header_valid), 32'(g.hv));
      if (o_header_valid) chk("hdr", 32'(o_header), 32'(g.hdr));
      last_data = o_data;
    end else begin
      chk("hold", o_data, last_data);
    end
    if (o_bitslip) begin
      if (slip_cnt > 0 && (cyc - last_slip_cyc) < min_gap) min_gap = cyc - last_slip_cyc;
      slip_cnt++;
      last_slip_cyc = cyc;
      hdr_since_slip = 0;
      if (slip_track) slip_off = (slip_off == 0) ? 65 : slip_off - 1;
    end
  endtask

  task automatic vbeat(input logic [31:0] plain, input logic [1:0] hdr, input logic hv);
    beat(plain, 1'b1, hdr, hv);
    beat_no++;
    if (pause_en && (beat_no % 63 == 0)) beat($urandom, 1'b0, 2'b00, 1'b0);
  endtask

  // One 66-bit block as two beats; exp_lock >= 0 checks lock right after the header beat.
  task automatic blk(input int exp_lock);
    logic [1:0]  h;
    logic [31:0] p0;
    logic [31:0] p1;
    if (mode_ctrl) begin
      p0 = 32'h0000_001e; p1 = 32'h0; h = SH_CTRL;
    end else begin
      p0 = $urandom; p1 = $urandom;
      h = ($urandom_range(0, 1) == 0) ? SH_DATA : SH_CTRL;
    end
    if (slip_off != 0) h = (slip_off % 2 == 1) ? 2'b11 : 2'b00;
    if (inj_bad > 0) begin
      h = (inj_bad % 2 == 1) ? 2'b00 : 2'b11;
      inj_bad--;
    end
    hdr_since_slip++;
    vbeat(p0, h, 1'b1);
    if (exp_lock >= 0) chk("lock_at_hdr", 32'(o_block_lock), 32'(exp_lock));
    vbeat(p1, 2'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_data_valid = 1'b0; i_header_valid = 1'b0;
    #1;
    chk("rst_lock", 32'(o_block_lock), 32'd0);
    chk("rst_bitslip", 32'(o_bitslip), 32'd0);
    chk("rst_dv", 32'(o_data_valid), 32'd0);
    chk("rst_hv", 32'(o_header_valid), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_hdr", 32'(o_header), 32'd0);
    chk("rst_err", 32'(o_sh_err_cnt), 32'd0);
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    last_data = 32'h0;
    sb_q.delete();
    repeat (4) beat($urandom, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    tbl[0] = '{2'b01, 1'b1, 1'b1, 16'd0, 1'b1};
    tbl[1] = '{2'b00, 1'b1, 1'b1, 16'd1, 1'b1};
    tbl[2] = '{2'b11, 1'b1, 1'b1, 16'd2, 1'b1};
    tbl[3] = '{2'b00, 1'b0, 1'b1, 16'd2, 1'b1};
    tbl[4] = '{2'b11, 1'b1, 1'b0, 16'd2, 1'b1};
    tbl[5] = '{2'b10, 1'b1, 1'b1, 16'd2, 1'b1};
    tbl[6] = '{2'b00, 1'b1, 1'b1, 16'd3, 1'b1};

    i_data = 32'h0; i_header = 2'b00; i_data_valid = 1'b0; i_header_valid = 1'b0;
    do_reset();

    // Lock acquisition on a clean stream.
    repeat (63) blk(-1);
    chk("lock_before_64", 32'(o_block_lock), 32'd0);
    blk(1);
    chk("acq_no_slip", 32'(slip_cnt), 32'd0);
    repeat (40) blk(-1);

    // Gearbox pauses.
    pause_en = 1'b1;
    repeat (80) blk(-1);
    pause_en = 1'b0;
    chk("pause_lock", 32'(o_block_lock), 32'd1);
    chk("pause_no_slip", 32'(slip_cnt), 32'd0);
    chk("pause_err", 32'(o_sh_err_cnt), 32'd0);

    // Header validity table while locked.
    for (int k = 0; k < 7; k++) begin
      beat($urandom, tbl[k].dv, tbl[k].hdr, tbl[k].hv);
      beat($urandom, 1'b1, 2'b00, 1'b0);
      chk("tbl_err", 32'(o_sh_err_cnt), 32'(tbl[k].exp_err));
      chk("tbl_lock", 32'(o_block_lock), 32'(tbl[k].exp_lock));
    end

    // Reset mid-frame, then a fresh 64-header relock.
    beat($urandom, 1'b1, SH_DATA, 1'b1);
    do_reset();
    repeat (63) blk(-1);
    chk("relock_before_64", 32'(o_block_lock), 32'd0);
    blk(1);

    // Lock loss: 15 invalid keeps lock, 16 drops it.
    slip_track = 1'b0;
    inj_bad = 15;
    repeat (15) blk(-1);
    chk("inv15_lock", 32'(o_block_lock), 32'd1);
    chk("inv15_err", 32'(o_sh_err_cnt), 32'd15);
    repeat (49) blk(-1);
    chk("inv15_window_lock", 32'(o_block_lock), 32'd1);
    inj_bad = 15;
    repeat (15) blk(-1);
    chk("inv_pre16_lock", 32'(o_block_lock), 32'd1);
    s0 = slip_cnt;
    beat($urandom, 1'b1, 2'b11, 1'b1);
    chk("inv16_lock", 32'(o_block_lock), 32'd0);
    chk("inv16_dv_same", 32'(o_data_valid), 32'd1);
    beat($urandom, 1'b1, 2'b00, 1'b0);
    chk("inv16_dv_next", 32'(o_data_valid), 32'd0);
    chk("inv16_err", 32'(o_sh_err_cnt), 32'd31);
    repeat (25) blk(-1);
    chk("inv16_one_slip", 32'(slip_cnt - s0), 32'd1);
    repeat (64) blk(-1);
    chk("loss_relock", 32'(o_block_lock), 32'd1);

    // Slip hunting from a 3-bit offset.
    slip_off = 3;
    slip_track = 1'b1;
    do_reset();
    slip_cnt = 0;
    min_gap = 100000;
    for (int k = 0; k < 400 && !o_block_lock; k++) blk(-1);
    chk("hunt_lock", 32'(o_block_lock), 32'd1);
    chk("hunt_slips", 32'(slip_cnt), 32'd3);
    chk("hunt_gap_ok", 32'(min_gap >= SLIP_WAIT_C), 32'd1);
    chk("hunt_hdrs_ok", 32'(hdr_since_slip >= 64 && hdr_since_slip <= 86), 32'd1);

    // START/idle control pattern through the descrambler.
    mode_ctrl = 1'b1;
    repeat (4) blk(-1);
    beat(32'h0000_001e, 1'b1, SH_CTRL, 1'b1);
    chk("ctrl_beat", o_data, 32'h0000_001e);
    beat(32'h0, 1'b1, 2'b00, 1'b0);
    chk("idle_beat", o_data, 32'h0);
    pause_en = 1'b1;
    repeat (70) blk(-1);
    chk("ctrl_final_lock", 32'(o_block_lock), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
